// File: rtl/mult3b_pkg.sv
// Shared constants and state type for the 3-bit multiply-accumulate block.
package mult3b_pkg;

  localparam int OP_W   = 3;
  localparam int PROD_W = 6;

  // ACC: collecting operand pairs; HOLD: frame result presented downstream.
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/mult3b_core.sv
// Pure combinational 3x3 unsigned multiplier; exact for every operand pair.
module mult3b_core
  import mult3b_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  // Widen both operands before multiplying so the 6-bit product is never truncated.
  always_comb begin
    p = PROD_W'(a) * PROD_W'(b);
  end

endmodule

// File: rtl/mult3b_acc.sv
// Frame accumulator: sums LEN products a*b, then holds the result (with a
// sticky overflow flag) until the consumer takes it.
//
// Handshake: an input transfer happens on a rising edge with
// in_valid & in_ready; an output transfer happens on a rising edge with
// out_valid & out_ready. in_ready is high only while collecting (ACC) and
// out_valid only while presenting (HOLD), so the two never overlap and a new
// frame starts no earlier than the cycle after the output transfer.
module mult3b_acc
  import mult3b_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int ACC_W = 10
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ov
);

  localparam logic [7:0] LEN_M1 = 8'(LEN - 1);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ov_q, ov_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [PROD_W-1:0]  prod;
  logic [ACC_W:0]     sum;
  logic               in_xfer;
  logic               out_xfer;

  mult3b_core u_core (
    .a (a),
    .b (b),
    .p (prod)
  );

  // Next-state logic: clr beats any transfer; the LEN-th input moves to HOLD.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ov_d     = ov_q;
    cnt_d    = cnt_q;
    in_xfer  = in_valid & (state_q == ACC);
    out_xfer = out_ready & (state_q == HOLD);
    // One extra bit captures the carry out of the accumulator's top bit.
    sum      = {1'b0, acc_q} + (ACC_W + 1)'(prod);
    if (clr) begin
      state_d = ACC;
      acc_d   = '0;
      ov_d    = 1'b0;
      cnt_d   = '0;
    end else if (in_xfer) begin
      acc_d = sum[ACC_W-1:0];
      ov_d  = ov_q | sum[ACC_W];
      cnt_d = cnt_q + 8'd1;
      if (cnt_q == LEN_M1) begin
        state_d = HOLD;
      end
    end else if (out_xfer) begin
      state_d = ACC;
      acc_d   = '0;
      ov_d    = 1'b0;
      cnt_d   = '0;
    end
  end

  // State registers; asynchronous reset drops any partial or pending frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs decode directly from state; acc/ov come straight from flops.
  always_comb begin
    in_ready  = (state_q == ACC);
    out_valid = (state_q == HOLD);
    acc       = acc_q;
    ov        = ov_q;
  end

endmodule

// File: tb/tb_mult3b_acc.sv
// Directed bench for mult3b_acc: three instances (LEN=4/ACC_W=10,
// LEN=6/ACC_W=8, LEN=1/ACC_W=10) sharing clock, rst and clr.
module tb_mult3b_acc;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       iv4, ir4, ov4_v, or4, ovf4;
  logic [2:0] a4, b4;
  logic [9:0] acc4;

  logic       iv6, ir6, ov6_v, or6, ovf6;
  logic [2:0] a6, b6;
  logic [7:0] acc6;

  logic       iv1, ir1, ov1_v, or1, ovf1;
  logic [2:0] a1, b1;
  logic [9:0] acc1;

  mult3b_acc #(.LEN(4), .ACC_W(10)) u_dut4 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .out_valid(ov4_v), .out_ready(or4), .acc(acc4), .ov(ovf4)
  );

  mult3b_acc #(.LEN(6), .ACC_W(8)) u_dut6 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(iv6), .in_ready(ir6),
    .a(a6), .b(b6), .out_valid(ov6_v), .out_ready(or6), .acc(acc6), .ov(ovf6)
  );

  mult3b_acc #(.LEN(1), .ACC_W(10)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .out_valid(ov1_v), .out_ready(or1), .acc(acc1), .ov(ovf1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one pair to the LEN=4 instance for exactly one edge.
  task automatic send4(input logic [2:0] a, input logic [2:0] b);
    iv4 = 1'b1; a4 = a; b4 = b;
    step();
    iv4 = 1'b0;
  endtask

  task automatic send6(input logic [2:0] a, input logic [2:0] b);
    iv6 = 1'b1; a6 = a; b6 = b;
    step();
    iv6 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    iv4 = 0; a4 = 0; b4 = 0; or4 = 0;
    iv6 = 0; a6 = 0; b6 = 0; or6 = 0;
    iv1 = 0; a1 = 0; b1 = 0; or1 = 0;

    // Reset state
    #2;
    check("rst_acc4", acc4, 0);
    check("rst_ir4", ir4, 1);
    check("rst_ov4_valid", ov4_v, 0);
    check("rst_ovf6", ovf6, 0);
    step();
    rst = 1'b0;
    step();

    // Four (7,7) back-to-back, out_ready=1 -> 196, out_valid exactly one cycle
    or4 = 1'b1;
    iv4 = 1'b1; a4 = 3'd7; b4 = 3'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bb_no_valid_early", ov4_v, 0);
    end
    step();
    iv4 = 1'b0;
    check("bb_valid", ov4_v, 1);
    check("bb_acc", acc4, 196);
    check("bb_ov", ovf4, 0);
    check("bb_ir_hold", ir4, 0);
    step();
    check("bb_valid_one_cycle", ov4_v, 0);
    check("bb_acc_cleared", acc4, 0);
    check("bb_ir_back", ir4, 1);

    // LEN=6, ACC_W=8: 6x(7,7) -> 294 mod 256 = 38, ov=1
    or6 = 1'b0;
    for (int i = 0; i < 6; i++) send6(3'd7, 3'd7);
    check("wrap_valid", ov6_v, 1);
    check("wrap_acc", acc6, 38);
    check("wrap_ov", ovf6, 1);
    or6 = 1'b1;
    step();
    or6 = 1'b0;
    check("wrap_drain_ov", ovf6, 0);
    for (int i = 0; i < 6; i++) send6(3'd1, 3'd1);
    check("next_valid", ov6_v, 1);
    check("next_acc", acc6, 6);
    check("next_ov", ovf6, 0);
    or6 = 1'b1;
    step();
    or6 = 1'b0;

    // Gapped input, out_ready held low: 15+0+36+2 = 53 held stable
    or4 = 1'b0;
    send4(3'd3, 3'd5);
    step();
    check("gap_acc_hold", acc4, 15);
    send4(3'd0, 3'd7);
    step();
    step();
    check("gap_acc_2", acc4, 15);
    send4(3'd6, 3'd6);
    step();
    check("gap_acc_3", acc4, 51);
    check("gap_no_valid", ov4_v, 0);
    send4(3'd2, 3'd1);
    check("gap_valid", ov4_v, 1);
    check("gap_acc", acc4, 53);
    iv4 = 1'b1; a4 = 3'd7; b4 = 3'd7;  // offered while in HOLD: must be ignored
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_acc", acc4, 53);
      check("hold_ir", ir4, 0);
      check("hold_valid", ov4_v, 1);
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    step();
    check("hold_drain_valid", ov4_v, 0);
    check("hold_drain_acc", acc4, 0);

    // Exhaustive LEN=1: each pair is a frame; result then drain = 2 cycles each
    or1 = 1'b1;
    iv1 = 1'b1;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        a1 = 3'(a); b1 = 3'(b);
        step();
        check("x_valid", ov1_v, 1);
        check("x_acc", acc1, 32'(a * b));
        step();
        check("x_drained", ov1_v, 0);
      end
    end
    iv1 = 1'b0;

    // Reset after 2 of 4 transfers: immediate clear, then 4x(1,2) -> 8
    or4 = 1'b1;
    send4(3'd3, 3'd3);
    send4(3'd3, 3'd3);
    check("pre_rst_acc", acc4, 18);
    rst = 1'b1;
    #1;
    check("async_rst_acc", acc4, 0);
    check("async_rst_ir", ir4, 1);
    rst = 1'b0;
    step();
    iv4 = 1'b1; a4 = 3'd1; b4 = 3'd2;
    for (int i = 0; i < 3; i++) step();
    check("post_rst_no_valid", ov4_v, 0);
    step();
    iv4 = 1'b0;
    check("post_rst_valid", ov4_v, 1);
    check("post_rst_acc", acc4, 8);
    step();

    // clr together with a transfer: the transfer is discarded
    iv4 = 1'b1; a4 = 3'd7; b4 = 3'd7; clr = 1'b1;
    step();
    clr = 1'b0; iv4 = 1'b0;
    check("clr_xfer_acc", acc4, 0);
    for (int i = 0; i < 3; i++) send4(3'd1, 3'd1);
    check("clr_cnt_no_valid", ov4_v, 0);
    send4(3'd1, 3'd1);
    check("clr_cnt_valid", ov4_v, 1);
    check("clr_cnt_acc", acc4, 4);
    step();

    // clr in HOLD with out_ready: clears result and sticky ov
    or6 = 1'b0;
    for (int i = 0; i < 6; i++) send6(3'd7, 3'd7);
    check("clr_hold_ov_set", ovf6, 1);
    clr = 1'b1; or6 = 1'b1;
    step();
    clr = 1'b0; or6 = 1'b0;
    check("clr_hold_valid", ov6_v, 0);
    check("clr_hold_ov", ovf6, 0);
    check("clr_hold_acc", acc6, 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
